// File: rtl/fifo_ctrl_ratio.sv
// ============================================================================
//  Module   : fifo_ctrl_ratio
//  Brief    : FIFO pointer/count controller; each write pushes RATIO words,
//             each read pops one. Optional sticky error flags are compiled in
//             with macro FIFO_CTRL_ERR_FLAGS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ctrl_ratio #(
    parameter int ADDR_WIDTH = 4,
    parameter int RATIO_LOG2 = 1,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - (1 << RATIO_LOG2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    output logic                  rd_accept,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  can_write,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int RATIO = 1 << RATIO_LOG2;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   RATIO_C  = (ADDR_WIDTH+1)'(RATIO);
    localparam logic [ADDR_WIDTH:0]   AF_C     = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] PTR_STEP = ADDR_WIDTH'(RATIO);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_next;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign can_write   = ((DEPTH_C - count_q) >= RATIO_C);
    assign almost_full = (count_q >= AF_C);

    // Acceptance looks only at the registered count: a same-cycle pop never
    // frees room for the push, and a same-cycle push never feeds the pop.
    assign wr_accept = reset & wr & can_write;
    assign rd_accept = reset & rd & ~empty;

    assign count_next = count_q
                      + (wr_accept ? RATIO_C : '0)
                      - {{ADDR_WIDTH{1'b0}}, rd_accept};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + PTR_STEP;
            if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
            count_q <= count_next;
        end
    end

    assign w_addr = wr_ptr;
    assign r_addr = rd_ptr;
    assign count  = count_q;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr & ~can_write) overflow_q  <= 1'b1;
            if (rd & empty)      underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl_ratio.sv
// ============================================================================
//  Module   : tb_fifo_ctrl_ratio
//  Brief    : Scoreboard bench for fifo_ctrl_ratio (ADDR_WIDTH=4, RATIO=2).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_ctrl_ratio;

    localparam int DEPTH = 16;
    localparam int RATIO = 2;
    localparam int AF    = 14;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       rd;
    logic       wr;
    logic       rd_accept;
    logic       wr_accept;
    logic [3:0] w_addr;
    logic [3:0] r_addr;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       can_write;
    logic       almost_full;
    logic       overflow;
    logic       underflow;

    fifo_ctrl_ratio #(
        .ADDR_WIDTH (4),
        .RATIO_LOG2 (1),
        .AF_LEVEL   (AF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd          (rd),
        .wr          (wr),
        .rd_accept   (rd_accept),
        .wr_accept   (wr_accept),
        .w_addr      (w_addr),
        .r_addr      (r_addr),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .can_write   (can_write),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of stored words plus running totals.
    int q_model[$];
    int exp_rd_q[$];
    int wr_total;
    int rd_total;
    bit ovf_m;
    bit unf_m;
    int seq;
    int lane_data[RATIO];
    int mem[DEPTH];
    int n_chk;
    int n_fail;
    int mon_exp;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q_model.delete();
        exp_rd_q.delete();
        wr_total = 0;
        rd_total = 0;
        ovf_m    = 1'b0;
        unf_m    = 1'b0;
    endtask

    task automatic check_state(input bit ew, input bit er);
        int c;
        c = q_model.size();
        chk("wr_accept",   int'(wr_accept),   int'(ew));
        chk("rd_accept",   int'(rd_accept),   int'(er));
        chk("count",       int'(count),       c);
        chk("empty",       int'(empty),       int'(c == 0));
        chk("full",        int'(full),        int'(c == DEPTH));
        chk("can_write",   int'(can_write),   int'(DEPTH - c >= RATIO));
        chk("almost_full", int'(almost_full), int'(c >= AF));
        chk("w_addr",      int'(w_addr),      (wr_total * RATIO) % DEPTH);
        chk("r_addr",      int'(r_addr),      rd_total % DEPTH);
        chk("overflow",    int'(overflow),    int'(ERR_EN && ovf_m));
        chk("underflow",   int'(underflow),   int'(ERR_EN && unf_m));
    endtask

    // One clock cycle of stimulus; entered and left at 1 time unit after posedge.
    task automatic step(input bit r, input bit w);
        int c;
        bit ew;
        bit er;
        rd = r;
        wr = w;
        for (int i = 0; i < RATIO; i++) lane_data[i] = seq + i;
        c  = q_model.size();
        ew = w && reset && (DEPTH - c >= RATIO);
        er = r && reset && (c > 0);
        if (er) exp_rd_q.push_back(q_model[0]);
        @(negedge clk);
        check_state(ew, er);
        if (er) begin
            void'(q_model.pop_front());
            rd_total++;
        end
        if (ew) begin
            for (int i = 0; i < RATIO; i++) q_model.push_back(seq + i);
            seq += RATIO;
            wr_total++;
        end
        if (reset) begin
            if (w && (DEPTH - c < RATIO)) ovf_m = 1'b1;
            if (r && c == 0)              unf_m = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: records lane writes into a shadow memory and checks read data order.
    always @(negedge clk) begin
        if (reset) begin
            if (wr_accept)
                for (int i = 0; i < RATIO; i++) mem[(int'(w_addr) + i) % DEPTH] = lane_data[i];
            if (rd_accept) begin
                if (exp_rd_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    mon_exp = exp_rd_q.pop_front();
                    chk("rd_data", mem[r_addr], mon_exp);
                end
            end
        end
    end

    task automatic pulse_reset_checked();
        reset = 1'b0;
        #2;
        model_clear();
        check_state(1'b0, 1'b0);
        step(1'b1, 1'b1);
        reset = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        seq    = 100;
        rd     = 1'b0;
        wr     = 1'b0;
        reset  = 1'b0;
        model_clear();
        #3;
        check_state(1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Mid-stream asynchronous reset at count=6.
        repeat (3) step(1'b0, 1'b1);
        chk("pre_reset_count", int'(count), 6);
        pulse_reset_checked();

        // Fill to full, then one write too many.
        repeat (8) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        // One read leaves 15: write with a concurrent read is still refused.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        // At 14 both are accepted.
        step(1'b1, 1'b1);
        while (q_model.size() > 0) step(1'b1, 1'b0);
        // From empty, simultaneous rd/wr: only the write goes through.
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        pulse_reset_checked();

        // Randomised traffic: write-heavy phase then read-heavy phase.
        for (int n = 0; n < 200; n++)
            step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 45);
        for (int n = 0; n < 200; n++)
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25);
        for (int n = 0; n < 40 && q_model.size() > 0; n++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        chk("scoreboard_drained", exp_rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
